// File: rtl/serv_rf_pkg.sv
// Shared state type and width helpers for the bit-serial register-file RAM bridge.
package serv_rf_pkg;

    localparam int CNT_W = 5;
    localparam int NBITS = 32;

    // state   | meaning
    // IDLE    | waiting for i_rreq
    // PRIME0  | word 0 of read port 0 returning from RAM
    // PRIME1  | word 0 of read port 1 returning from RAM
    // ACTIVE  | serial read in progress, prefetching next words
    // CLEAR   | zeroing every register word after reset (SERV_RF_BRIDGE_CLEAR_EN only)
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME0,
        ST_PRIME1,
        ST_ACTIVE,
        ST_CLEAR
    } state_t;

    function automatic int nreg(input int with_csr);
        return 32 + 4 * with_csr;
    endfunction

    function automatic int reg_w(input int with_csr);
        return 5 + with_csr;
    endfunction

    function automatic int word_w(input int rw);
        return $clog2(NBITS / rw);
    endfunction

    function automatic int addr_w(input int with_csr, input int rw);
        return reg_w(with_csr) + word_w(rw);
    endfunction

    function automatic bit rw_legal(input int rw);
        return (rw == 4) || (rw == 8) || (rw == 16);
    endfunction

endpackage

// File: rtl/serv_rf_ram_wbuf.sv
// Write deserialiser for one RF write port: collects RW serial bits and holds the
// finished word, its address and its enable until the top-level arbiter commits it.
module serv_rf_ram_wbuf
    import serv_rf_pkg::*;
#(
    parameter int RW  = 4,
    parameter int RGW = 6,
    parameter int WW  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_shift,
    input  logic              i_latch,
    input  logic [RGW-1:0]    i_wreg,
    input  logic [WW-1:0]     i_word,
    input  logic              i_wen,
    input  logic              i_wdata,
    output logic              o_wen,
    output logic [RGW+WW-1:0] o_waddr,
    output logic [RW-1:0]     o_wdata
);

    logic [RW-2:0]     r_wsr;
    logic              r_hold_wen;
    logic [RGW+WW-1:0] r_hold_addr;
    logic [RW-1:0]     r_hold_data;

    // The final bit of a word goes straight into the hold, so only RW-1 bits are shifted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wsr       <= '0;
            r_hold_wen  <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else begin
            if (i_shift) begin
                r_wsr <= {i_wdata, r_wsr[RW-2:1]};
            end
            if (i_latch) begin
                r_hold_data <= {i_wdata, r_wsr};
                r_hold_addr <= {i_wreg, i_word};
                r_hold_wen  <= i_wen;
            end
        end
    end

    assign o_wen   = r_hold_wen;
    assign o_waddr = r_hold_addr;
    assign o_wdata = r_hold_data;

endmodule

// File: rtl/serv_rf_ram_bridge.sv
// Bit-serial RF ports to RW-wide dual-port RAM bridge with word prefetch and write commit.
// Optional SERV_RF_BRIDGE_CLEAR_EN: zero all register words after reset before serving reads.
module serv_rf_ram_bridge
    import serv_rf_pkg::*;
#(
    parameter int WITH_CSR = 1,
    parameter int RW       = 4,
    parameter int AW       = addr_w(WITH_CSR, RW)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cnt_en,
    input  logic                    i_rreq,
    output logic                    o_ready,
    input  logic [reg_w(WITH_CSR)-1:0] i_rreg0,
    input  logic [reg_w(WITH_CSR)-1:0] i_rreg1,
    output logic                    o_rdata0,
    output logic                    o_rdata1,
    input  logic [reg_w(WITH_CSR)-1:0] i_wreg0,
    input  logic [reg_w(WITH_CSR)-1:0] i_wreg1,
    input  logic                    i_wen0,
    input  logic                    i_wen1,
    input  logic                    i_wdata0,
    input  logic                    i_wdata1,
    output logic [AW-1:0]           o_waddr,
    output logic [RW-1:0]           o_wdata,
    output logic                    o_wen,
    output logic [AW-1:0]           o_raddr,
    output logic                    o_ren,
    input  logic [RW-1:0]           i_rdata
);

    localparam int RGW = reg_w(WITH_CSR);
    localparam int WW  = word_w(RW);
    localparam int OW  = CNT_W - WW;

    if (!rw_legal(RW)) begin : g_bad_rw
        $error("serv_rf_ram_bridge: RW must be 4, 8 or 16");
    end
    if (AW != RGW + WW) begin : g_bad_aw
        $error("serv_rf_ram_bridge: AW is derived and must not be overridden");
    end

`ifdef SERV_RF_BRIDGE_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
    // Only real register words are cleared, so the sweep stops at NREG*words rather than 2^AW.
    localparam logic [AW-1:0] CLR_LAST = AW'(nreg(WITH_CSR) * (NBITS / RW) - 1);
    logic [AW-1:0] r_clr_addr;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [RW-1:0]    r_sr0, r_sr1, r_stg0, r_stg1;
    logic             r_cap0, r_cap1, r_ready;
    logic             r_commit0, r_commit1;
    logic [WW-1:0]    w_word, w_word_nxt;
    logic [OW-1:0]    w_off;
    logic             w_last_bit, w_wlast, w_pf0, w_pf1;
    logic             w_h0_wen, w_h1_wen;
    logic [AW-1:0]    w_h0_addr, w_h1_addr;
    logic [RW-1:0]    w_h0_data, w_h1_data;

    assign w_word     = r_cnt[CNT_W-1 -: WW];
    assign w_off      = r_cnt[OW-1:0];
    assign w_word_nxt = w_word + WW'(1);
    assign w_last_bit = &w_off;
    assign w_wlast    = i_cnt_en & w_last_bit;

    always_comb begin
        w_state_nxt = r_state;
        o_ren       = 1'b0;
        o_raddr     = '0;
        w_pf0       = 1'b0;
        w_pf1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rreq) begin
                    w_state_nxt = ST_PRIME0;
                    o_ren       = 1'b1;
                    o_raddr     = {i_rreg0, {WW{1'b0}}};
                end
            end
            ST_PRIME0: begin
                w_state_nxt = ST_PRIME1;
                o_ren       = 1'b1;
                o_raddr     = {i_rreg1, {WW{1'b0}}};
            end
            ST_PRIME1: w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (i_cnt_en && (w_word != '1)) begin
                    if (w_off == '0) begin
                        w_pf0   = 1'b1;
                        o_ren   = 1'b1;
                        o_raddr = {i_rreg0, w_word_nxt};
                    end else if (w_off == OW'(1)) begin
                        w_pf1   = 1'b1;
                        o_ren   = 1'b1;
                        o_raddr = {i_rreg1, w_word_nxt};
                    end
                end
                if (i_cnt_en && (r_cnt == '1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef SERV_RF_BRIDGE_CLEAR_EN
            ST_CLEAR: begin
                if (r_clr_addr == CLR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RESET;
            r_cnt     <= '0;
            r_sr0     <= '0;
            r_sr1     <= '0;
            r_stg0    <= '0;
            r_stg1    <= '0;
            r_cap0    <= 1'b0;
            r_cap1    <= 1'b0;
            r_ready   <= 1'b0;
            r_commit0 <= 1'b0;
            r_commit1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (r_state == ST_PRIME1);
            r_cap0    <= w_pf0;
            r_cap1    <= w_pf1;
            r_commit0 <= w_wlast;
            r_commit1 <= r_commit0;
            if (i_cnt_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cap0) begin
                r_stg0 <= i_rdata;
            end
            if (r_cap1) begin
                r_stg1 <= i_rdata;
            end
            if (r_state == ST_PRIME0) begin
                r_sr0 <= i_rdata;
            end
            if (r_state == ST_PRIME1) begin
                r_sr1 <= i_rdata;
            end
            if ((r_state == ST_ACTIVE) && i_cnt_en) begin
                if (w_last_bit) begin
                    r_sr0 <= r_stg0;
                    r_sr1 <= r_stg1;
                end else begin
                    r_sr0 <= r_sr0 >> 1;
                    r_sr1 <= r_sr1 >> 1;
                end
            end
        end
    end

`ifdef SERV_RF_BRIDGE_CLEAR_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + AW'(1);
        end
    end
`endif

    assign o_ready  = r_ready;
    assign o_rdata0 = (r_state == ST_ACTIVE) & r_sr0[0];
    assign o_rdata1 = (r_state == ST_ACTIVE) & r_sr1[0];

    serv_rf_ram_wbuf #(.RW(RW), .RGW(RGW), .WW(WW)) u_wbuf0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_shift (i_cnt_en),
        .i_latch (w_wlast),
        .i_wreg  (i_wreg0),
        .i_word  (w_word),
        .i_wen   (i_wen0),
        .i_wdata (i_wdata0),
        .o_wen   (w_h0_wen),
        .o_waddr (w_h0_addr),
        .o_wdata (w_h0_data)
    );

    serv_rf_ram_wbuf #(.RW(RW), .RGW(RGW), .WW(WW)) u_wbuf1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_shift (i_cnt_en),
        .i_latch (w_wlast),
        .i_wreg  (i_wreg1),
        .i_word  (w_word),
        .i_wen   (i_wen1),
        .i_wdata (i_wdata1),
        .o_wen   (w_h1_wen),
        .o_waddr (w_h1_addr),
        .o_wdata (w_h1_data)
    );

    // Port 0 commits the cycle after a word completes, port 1 the cycle after that.
    always_comb begin
        o_wen   = 1'b0;
        o_waddr = '0;
        o_wdata = '0;
        if (r_commit0) begin
            o_wen   = w_h0_wen;
            o_waddr = w_h0_addr;
            o_wdata = w_h0_data;
        end else if (r_commit1) begin
            o_wen   = w_h1_wen;
            o_waddr = w_h1_addr;
            o_wdata = w_h1_data;
        end
`ifdef SERV_RF_BRIDGE_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            o_wen   = 1'b1;
            o_waddr = r_clr_addr;
            o_wdata = '0;
        end
`endif
    end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Directed self-checking bench for serv_rf_ram_bridge (WITH_CSR=1, RW=4) with a behavioural RAM.
module tb_serv_rf_ram_bridge;

    localparam int AW = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cnt_en, rreq;
    logic [5:0] rreg0, rreg1, wreg0, wreg1;
    logic       wen0, wen1, wdata0, wdata1;
    logic       o_ready, o_rdata0, o_rdata1, o_wen, o_ren;
    logic [AW-1:0] o_waddr, o_raddr;
    logic [3:0] o_wdata;
    logic [3:0] ram_rdata;

    logic [3:0] mem [0:511];
    logic [AW-1:0] raddr_q [$];
    int wen_cnt = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] d0, d1;

    always #5 clk = ~clk;

    serv_rf_ram_bridge #(.WITH_CSR(1), .RW(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_cnt_en (cnt_en),
        .i_rreq   (rreq),
        .o_ready  (o_ready),
        .i_rreg0  (rreg0),
        .i_rreg1  (rreg1),
        .o_rdata0 (o_rdata0),
        .o_rdata1 (o_rdata1),
        .i_wreg0  (wreg0),
        .i_wreg1  (wreg1),
        .i_wen0   (wen0),
        .i_wen1   (wen1),
        .i_wdata0 (wdata0),
        .i_wdata1 (wdata1),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen),
        .o_raddr  (o_raddr),
        .o_ren    (o_ren),
        .i_rdata  (ram_rdata)
    );

    always @(posedge clk) begin
        if (o_ren) begin
            ram_rdata <= mem[o_raddr];
            raddr_q.push_back(o_raddr);
        end
        if (o_wen) begin
            mem[o_waddr] = o_wdata;
            wen_cnt = wen_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input int r, input logic [31:0] v);
        for (int w = 0; w < 8; w++) mem[r * 8 + w] = v[4 * w +: 4];
    endtask

    function automatic logic [31:0] mem_word(input int r);
        logic [31:0] v;
        for (int w = 0; w < 8; w++) v[4 * w +: 4] = mem[r * 8 + w];
        return v;
    endfunction

    task automatic start_read(input logic [5:0] a, input logic [5:0] b);
        int n;
        @(negedge clk);
        rreg0 = a;
        rreg1 = b;
        rreq  = 1'b1;
        @(negedge clk);
        rreq = 1'b0;
        n = 1;
        while (!o_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", n, 3);
        @(negedge clk);
        check("ready_pulse", o_ready, 0);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [5:0] b, input int gap,
                           output logic [31:0] r0, output logic [31:0] r1);
        start_read(a, b);
        for (int i = 0; i < 32; i++) begin
            r0[i] = o_rdata0;
            r1[i] = o_rdata1;
            cnt_en = 1'b1;
            @(negedge clk);
            cnt_en = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [5:0] r0, input logic [31:0] v0, input logic [7:0] m0,
                            input logic [5:0] r1, input logic [31:0] v1, input logic [7:0] m1);
        for (int i = 0; i < 32; i++) begin
            wreg0  = r0;
            wreg1  = r1;
            wdata0 = v0[i];
            wdata1 = v1[i];
            wen0   = m0[i / 4];
            wen1   = m1[i / 4];
            cnt_en = 1'b1;
            @(negedge clk);
        end
        cnt_en = 1'b0;
        wen0   = 1'b0;
        wen1   = 1'b0;
        wdata0 = 1'b0;
        wdata1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic post_reset();
`ifdef SERV_RF_BRIDGE_CLEAR_EN
        int base;
        int n;
        base = wen_cnt;
        n = 0;
        while ((wen_cnt - base) < 288 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("clear_writes", wen_cnt - base, 288);
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        int base;
        for (int i = 0; i < 512; i++) mem[i] = 4'h9;
        ram_rdata = '0;
        rst_n  = 1'b0;
        cnt_en = 1'b0;
        rreq   = 1'b0;
        rreg0  = '0;
        rreg1  = '0;
        wreg0  = '0;
        wreg1  = '0;
        wen0   = 1'b0;
        wen1   = 1'b0;
        wdata0 = 1'b0;
        wdata1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", o_ready, 0);
        check("rst_wen", o_wen, 0);
        check("rst_ren", o_ren, 0);
        check("rst_rdata0", o_rdata0, 0);
        check("rst_rdata1", o_rdata1, 0);
        rst_n = 1'b1;
        post_reset();
`ifdef SERV_RF_BRIDGE_CLEAR_EN
        do_read(6'd5, 6'd6, 0, d0, d1);
        check("clear_x5", d0, 32'h0);
`endif

        preload(5, 32'hDEADBEEF);
        preload(6, 32'h12345678);
        do_read(6'd5, 6'd6, 0, d0, d1);
        check("read_x5", d0, 32'hDEADBEEF);
        check("read_x6", d1, 32'h12345678);

        raddr_q.delete();
        do_read(6'd5, 6'd6, 2, d0, d1);
        check("gap_read_x5", d0, 32'hDEADBEEF);
        check("gap_read_x6", d1, 32'h12345678);
        check("raddr_count", raddr_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < raddr_q.size())
                check("raddr_seq", raddr_q[i], {(i % 2 == 0) ? 6'd5 : 6'd6, 3'(i / 2)});
        end

        base = wen_cnt;
        do_write(6'd7, 32'hA5A5A5A5, 8'hFF, 6'd34, 32'h80000004, 8'hFF);
        check("write_count", wen_cnt - base, 16);
        check("mem_x7", mem_word(7), 32'hA5A5A5A5);
        check("mem_mepc", mem_word(34), 32'h80000004);
        do_read(6'd7, 6'd34, 0, d0, d1);
        check("readback_x7", d0, 32'hA5A5A5A5);
        check("readback_mepc", d1, 32'h80000004);

        base = wen_cnt;
        do_write(6'd7, 32'h3C3C3C3C, 8'hF7, 6'd0, 32'hFFFFFFFF, 8'h00);
        check("masked_write_count", wen_cnt - base, 7);
        check("masked_x7", mem_word(7), 32'h3C3CAC3C);

        start_read(6'd5, 6'd6);
        repeat (13) begin
            cnt_en = 1'b1;
            @(negedge clk);
            cnt_en = 1'b0;
        end
        check("pre_rst_bit13", o_rdata0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rdata0", o_rdata0, 0);
        check("midrst_rdata1", o_rdata1, 0);
        check("midrst_ready", o_ready, 0);
        check("midrst_ren", o_ren, 0);
        check("midrst_wen", o_wen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset();
`ifdef SERV_RF_BRIDGE_CLEAR_EN
        preload(5, 32'hDEADBEEF);
        preload(6, 32'h12345678);
`endif
        do_read(6'd5, 6'd6, 0, d0, d1);
        check("post_rst_x5", d0, 32'hDEADBEEF);
        check("post_rst_x6", d1, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
